regfile_2r1w_clr: RTL and testbench
===================================

Name: regfile_2r1w_clr

Overview:
- Parametrised register file: one synchronous write port and two independent read ports.
- Storage behaves as distributed RAM: combinational read, write on the clock edge.
- Adds a hardware clear sequencer that initialises every word after reset and on request, an optional write-through bypass, and an optional registered read stage.
- Intended as the general successor to the 64x1 single-read dual-port cell, used for CPU register files and small lookup tables.

Parameters:
- W, 32, data width in bits (1..64).
- AW, 6, address width; depth DEPTH = 2^AW words.
- INIT_VAL, 0, W-bit value written to every word by the clear sequencer.
- BYPASS, 1, 1 = write-first forwarding from the write port to the read ports; 0 = read returns the pre-write contents.
- READ_REG, 0, 0 = combinational read outputs; 1 = read outputs registered (1-cycle latency).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- in  in  W  write data.
- wa  in  AW  write address.
- we  in  1  write enable; honoured only when busy=0.
- ra0  in  AW  read address, port 0.
- ra1  in  AW  read address, port 1.
- out0  out  W  read data, port 0.
- out1  out  W  read data, port 1.
- clr  in  1  request a full re-initialisation to INIT_VAL.
- busy  out  1  clear sequence in progress; user writes are ignored while high.

Behaviour:
- The clock is CLK. Reset is RESETn: asynchronous and active-low. These are fixed.

State machine: two states, CLEAR and RUN, with an AW-bit clear counter cnt.
- Reset asserted: state=CLEAR, cnt=0, busy=1; registered outputs (READ_REG=1) = 0. Storage contents are not reset.
- CLEAR, each rising edge: write INIT_VAL to address cnt, then cnt++.
  - The edge that writes DEPTH-1 moves to RUN and sets cnt=0.
  - busy is a registered copy of (state==CLEAR). It is 1 for exactly DEPTH cycles after RESETn releases.
  - The first user write is accepted on edge DEPTH+1.
- RUN with we=1: in is written to wa on the rising edge.
- RUN with clr=1: go to CLEAR with cnt=0 on the next edge.
  - clr has priority over we in the same cycle; that write is dropped.
- clr in CLEAR: ignored; the sequence does not restart.
- Reset mid-clear: the sequence restarts from address 0 when reset releases.
- we during CLEAR: ignored; no storage change.

Read path:
- READ_REG=0: outN = mem[raN] combinationally, same cycle.
- READ_REG=1: outN is registered at the edge from the same combinational value, so data appears one cycle after the address.
- While busy=1 the read data is forced to INIT_VAL, so stale contents never leak out.
- BYPASS=1, in RUN, with we=1 and wa==raN: the read data is in (write-first), for both ports independently.
- BYPASS=0 in the same situation: the read data is the old mem[raN]. The new value is visible from the next cycle.
- Both ports may read the same address; each returns identical data.

Widths and range:
- All addresses are full AW bits, so there is no out-of-range case.
- cnt wraps only via the explicit transition to RUN.

Test Plan:
1. Reset release, W=32, AW=6, INIT_VAL=32'hDEADBEEF -> busy=1 for exactly 64 cycles, then 0; ra0=0..63 all read 32'hDEADBEEF.
2. RUN, write 32'h12345678 to wa=5; next cycle ra0=5, ra1=6 -> out0=32'h12345678, out1=32'hDEADBEEF.
3. Forwarding: we=1, wa=ra0=ra1=9, in=32'hA5A5A5A5.
   - BYPASS=1 -> out0=out1=32'hA5A5A5A5 in that cycle.
   - BYPASS=0 -> old value that cycle, 32'hA5A5A5A5 the next cycle.
4. we=1 to wa=3 with in=32'h1 while busy=1 -> after clear completes, ra0=3 reads INIT_VAL.
5. RUN, clr=1 and we=1 (wa=7, in=32'h77) in the same cycle -> busy=1 for 64 cycles; afterwards addr 7 and all others read INIT_VAL.
6. Reset mid-clear at cnt=20, held for 3 cycles, then released -> busy=1 for 64 further cycles; all words read INIT_VAL.
7. READ_REG=1: write 32'hCAFE0001 to addr 2, then apply ra0=2 at cycle t -> out0=32'hCAFE0001 at cycle t+1; out0=0 during reset.

Source files
------------

// File: rtl/regfile_2r1w_clr_if.sv
// Bus bundle for regfile_2r1w_clr: one write port, two read ports, clear request and busy flag.
interface regfile_2r1w_clr_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 6
);
    logic [W-1:0]  in;
    logic [AW-1:0] wa;
    logic          we;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [W-1:0]  out0;
    logic [W-1:0]  out1;
    logic          clr;
    logic          busy;

    modport master (
        output in, wa, we, ra0, ra1, clr,
        input  out0, out1, busy
    );

    modport slave (
        input  in, wa, we, ra0, ra1, clr,
        output out0, out1, busy
    );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// 2-read/1-write register file with a clear sequencer that writes INIT_VAL to every word after
// reset or on request, optional write-first bypass and optional registered read outputs.
module regfile_2r1w_clr #(
    parameter int unsigned   W        = 32,
    parameter int unsigned   AW       = 6,
    parameter logic [W-1:0]  INIT_VAL = '0,
    parameter bit            BYPASS   = 1'b1,
    parameter bit            READ_REG = 1'b0
) (
    input logic                CLK,
    input logic                RESETn,
    regfile_2r1w_clr_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    logic [W-1:0]  mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [W-1:0]  mem_wd;
    logic          fwd0, fwd1;
    logic [W-1:0]  rd0, rd1;

    // busy_q is updated together with state_q so it always equals (state == CLEAR).
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StClear: begin
                    if (&cnt_q) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (bus.clr) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // clr wins over we; a user write only lands in RUN.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.wa;
        mem_wd = bus.in;
        if (state_q == StClear) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = INIT_VAL;
        end else if (bus.we && !bus.clr) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        fwd0 = BYPASS && !busy_q && bus.we && !bus.clr && (bus.wa == bus.ra0);
        fwd1 = BYPASS && !busy_q && bus.we && !bus.clr && (bus.wa == bus.ra1);
        if (busy_q) begin
            rd0 = INIT_VAL;
            rd1 = INIT_VAL;
        end else begin
            rd0 = fwd0 ? bus.in : mem[bus.ra0];
            rd1 = fwd1 ? bus.in : mem[bus.ra1];
        end
    end

    generate
        if (READ_REG) begin : g_read_reg
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    bus.out0 <= '0;
                    bus.out1 <= '0;
                end else begin
                    bus.out0 <= rd0;
                    bus.out1 <= rd1;
                end
            end
        end else begin : g_read_comb
            assign bus.out0 = rd0;
            assign bus.out1 = rd1;
        end
    endgenerate

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Scoreboard bench: three register files (bypass, no bypass, registered read) share one stimulus
// stream; a reference model queues expected outputs, a negedge monitor pops and compares.
module tb_regfile_2r1w_clr;
    localparam logic [31:0] INIT = 32'hDEADBEEF;
    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        clrv, wev;
    logic [5:0]  wav, ra0v, ra1v;
    logic [31:0] dinv;

    regfile_2r1w_clr_if #(.W(32), .AW(6)) ifa ();
    regfile_2r1w_clr_if #(.W(32), .AW(6)) ifb ();
    regfile_2r1w_clr_if #(.W(32), .AW(6)) ifc ();

    assign ifa.in = dinv;  assign ifa.wa = wav;  assign ifa.we = wev;
    assign ifa.ra0 = ra0v; assign ifa.ra1 = ra1v; assign ifa.clr = clrv;
    assign ifb.in = dinv;  assign ifb.wa = wav;  assign ifb.we = wev;
    assign ifb.ra0 = ra0v; assign ifb.ra1 = ra1v; assign ifb.clr = clrv;
    assign ifc.in = dinv;  assign ifc.wa = wav;  assign ifc.we = wev;
    assign ifc.ra0 = ra0v; assign ifc.ra1 = ra1v; assign ifc.clr = clrv;

    regfile_2r1w_clr #(.W(32), .AW(6), .INIT_VAL(INIT), .BYPASS(1'b1), .READ_REG(1'b0)) dut_a (
        .CLK(clk), .RESETn(rst_n), .bus(ifa));
    regfile_2r1w_clr #(.W(32), .AW(6), .INIT_VAL(INIT), .BYPASS(1'b0), .READ_REG(1'b0)) dut_b (
        .CLK(clk), .RESETn(rst_n), .bus(ifb));
    regfile_2r1w_clr #(.W(32), .AW(6), .INIT_VAL(INIT), .BYPASS(1'b1), .READ_REG(1'b1)) dut_c (
        .CLK(clk), .RESETn(rst_n), .bus(ifc));

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [31:0] a0, a1, b0, b1, c0, c1;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: word array plus the number of clear writes still owed.
    logic [31:0] mref [DEPTH];
    int          remaining;
    logic [31:0] rc0, rc1;

    function automatic logic [31:0] mread(input logic [5:0] ra, input bit byp);
        if (remaining > 0) return INIT;
        if (byp && wev && !clrv && wav == ra) return dinv;
        return mref[ra];
    endfunction

    task automatic step(input logic r, input logic c, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input logic [5:0] r0, input logic [5:0] r1);
        exp_t e;
        rst_n = r; clrv = c; wev = w; wav = a; dinv = d; ra0v = r0; ra1v = r1;
        if (!r) begin
            remaining = DEPTH;
            rc0 = '0;
            rc1 = '0;
        end
        e.busy = (remaining > 0);
        e.a0 = mread(r0, 1'b1); e.a1 = mread(r1, 1'b1);
        e.b0 = mread(r0, 1'b0); e.b1 = mread(r1, 1'b0);
        e.c0 = rc0;             e.c1 = rc1;
        sbq.push_back(e);
        @(posedge clk);
        if (r) begin
            rc0 = mread(r0, 1'b1);
            rc1 = mread(r1, 1'b1);
            if (remaining > 0) begin
                mref[DEPTH - remaining] = INIT;
                remaining--;
            end else if (c) begin
                remaining = DEPTH;
            end else if (w) begin
                mref[a] = d;
            end
        end
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("busy_a", {31'd0, ifa.busy}, {31'd0, e.busy});
            chk("busy_b", {31'd0, ifb.busy}, {31'd0, e.busy});
            chk("busy_c", {31'd0, ifc.busy}, {31'd0, e.busy});
            chk("byp_out0", ifa.out0, e.a0);
            chk("byp_out1", ifa.out1, e.a1);
            chk("nobyp_out0", ifb.out0, e.b0);
            chk("nobyp_out1", ifb.out1, e.b1);
            chk("reg_out0", ifc.out0, e.c0);
            chk("reg_out1", ifc.out1, e.c1);
        end
    end

    initial begin
        rst_n = 1'b1; clrv = 1'b0; wev = 1'b0; wav = '0; dinv = '0; ra0v = '0; ra1v = '0;
        remaining = DEPTH; rc0 = '0; rc1 = '0;
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
        // Clear after reset; writes to addr 3 while busy must be dropped.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, (i < 10), 6'd3, 32'h1, 6'(i), 6'(63 - i));
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'(i), 6'(63 - i));
        step(1'b1, 1'b0, 1'b1, 6'd5, 32'h12345678, 6'd0, 6'd0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'd5, 6'd6);
        step(1'b1, 1'b0, 1'b1, 6'd9, 32'hA5A5A5A5, 6'd9, 6'd9);
        step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'd9, 6'd9);
        // clr and we together: the write is dropped.
        step(1'b1, 1'b1, 1'b1, 6'd7, 32'h77, 6'd7, 6'd5);
        for (int i = 0; i < 66; i++)
            step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'd7, 6'(i % 64));
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'(i), 6'(63 - i));
        step(1'b1, 1'b0, 1'b1, 6'd2, 32'hCAFE0001, 6'd0, 6'd1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'd2, 6'd2);
        step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'd3, 6'd2);
        for (int i = 0; i < 400; i++)
            step(1'b1, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 15)), $urandom, 6'($urandom_range(0, 15)),
                 6'($urandom_range(0, 63)));
        for (int i = 0; i < 70; i++)
            step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'(i % 64), 6'd0);
        // Reset in the middle of a clear restarts the sequence from address 0.
        step(1'b1, 1'b1, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b1, 6'(i), 32'hFFFF0000, 6'(i), 6'd2);
        repeat (3) step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd2, 6'd5);
        for (int i = 0; i < 66; i++)
            step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'd2, 6'(i % 64));
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 6'(i), 6'(63 - i));
        repeat (2) @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
